// File: rtl/ym_bus_responder.sv
// PSG-side BDIR/BC1 bus responder: synchronizes the decoder's bus controls, decodes
// AY/YM bus modes, and keeps the masked 16-entry register file the sound core reads.
//
// state | meaning
// IDLE  | bus inactive (BDIR=0, BC1=0)
// READ  | CPU reading the latched register (BDIR=0, BC1=1)
// WRITE | CPU writing the latched register (BDIR=1, BC1=0)
// LATCH | CPU latching a register address (BDIR=1, BC1=1)
module ym_bus_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] ADDR_HI     = 4'h0,
    parameter logic       CHIP_ID     = 1'b0
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       bdir,
    input  logic       bc1,
    input  logic       chip_sel,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [3:0] core_addr,
    output logic [7:0] core_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic       env_restart
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        LATCH = 2'b11
    } mode_t;

    logic [SYNC_STAGES-1:0] bdir_q;
    logic [SYNC_STAGES-1:0] bc1_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [7:0]             d_q;
    logic [7:0]             captured;
    logic                   cap_valid;
    logic [3:0]             addr;
    logic                   pend_wr;
    logic [3:0]             pend_addr;
    logic [7:0]             regs [16];
    mode_t                  state;
    mode_t                  mode;
    logic                   selected;

    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13:  reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:  reg_mask = 8'h1F;
            default:                  reg_mask = 8'hFF;
        endcase
    endfunction

    assign mode      = mode_t'({bdir_q[SYNC_STAGES-1], bc1_q[SYNC_STAGES-1]});
    assign selected  = (cs_q[SYNC_STAGES-1] == CHIP_ID);
    assign core_data = regs[core_addr] & reg_mask(core_addr);

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            bdir_q      <= '0;
            bc1_q       <= '0;
            cs_q        <= '0;
            d_q         <= 8'h00;
            captured    <= 8'h00;
            cap_valid   <= 1'b0;
            addr        <= 4'h0;
            pend_wr     <= 1'b0;
            pend_addr   <= 4'h0;
            state       <= IDLE;
            d_out       <= 8'h00;
            d_oe        <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 4'h0;
            env_restart <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            bdir_q <= {bdir_q[SYNC_STAGES-2:0], bdir};
            bc1_q  <= {bc1_q[SYNC_STAGES-2:0], bc1};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], chip_sel};
            d_q    <= d_in;
            state  <= mode;

            // Strobes trail the register update by one cycle.
            wr_strobe   <= pend_wr;
            env_restart <= pend_wr && (pend_addr == 4'd13);
            if (pend_wr) wr_addr <= pend_addr;
            pend_wr <= 1'b0;

            d_oe  <= (mode == READ) && selected;
            d_out <= ((mode == READ) && selected) ? (regs[addr] & reg_mask(addr)) : 8'h00;

            // Act on the trailing edge of a mode, like the real chip.
            if (state != mode) begin
                cap_valid <= 1'b0;
                if (cap_valid && state == LATCH && captured[7:4] == ADDR_HI)
                    addr <= captured[3:0];
                if (cap_valid && state == WRITE) begin
                    regs[addr] <= captured & reg_mask(addr);
                    pend_wr    <= 1'b1;
                    pend_addr  <= addr;
                end
            end else if ((state == WRITE || state == LATCH) && selected) begin
                captured  <= d_q;
                cap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ym_bus_responder.sv
// Directed bench for ym_bus_responder: two instances (CHIP_ID 0 and 1) on a shared bus.
module tb_ym_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       bdir, bc1, chip_sel;
    logic [7:0] d_in;
    logic [3:0] core_addr;
    logic [7:0] d_out0, d_out1, core_data0, core_data1;
    logic       d_oe0, d_oe1, wr_strobe0, wr_strobe1, env0, env1;
    logic [3:0] wr_addr0, wr_addr1;

    int n_cmp  = 0;
    int n_fail = 0;

    int stb0_cnt = 0, stb1_cnt = 0, env0_cnt = 0, both0_cnt = 0;

    always #5 clk = ~clk;

    ym_bus_responder #(.SYNC_STAGES(2), .ADDR_HI(4'h0), .CHIP_ID(1'b0)) u0 (
        .cpu_clock(clk), .reset(reset), .bdir(bdir), .bc1(bc1), .chip_sel(chip_sel),
        .d_in(d_in), .d_out(d_out0), .d_oe(d_oe0), .core_addr(core_addr),
        .core_data(core_data0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
        .env_restart(env0)
    );

    ym_bus_responder #(.SYNC_STAGES(2), .ADDR_HI(4'h0), .CHIP_ID(1'b1)) u1 (
        .cpu_clock(clk), .reset(reset), .bdir(bdir), .bc1(bc1), .chip_sel(chip_sel),
        .d_in(d_in), .d_out(d_out1), .d_oe(d_oe1), .core_addr(core_addr),
        .core_data(core_data1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
        .env_restart(env1)
    );

    always @(negedge clk) begin
        if (wr_strobe0) stb0_cnt++;
        if (wr_strobe1) stb1_cnt++;
        if (env0) env0_cnt++;
        if (wr_strobe0 && env0) both0_cnt++;
    end

    task automatic bus_op(input logic b, input logic c, input logic [7:0] d);
        @(negedge clk);
        bdir = b; bc1 = c; d_in = d;
        repeat (4) @(negedge clk);
        bdir = 1'b0; bc1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_read(output int oe0_cycles, output int oe1_cycles,
                           output logic [7:0] rd0, output logic [7:0] rd1);
        oe0_cycles = 0; oe1_cycles = 0; rd0 = 8'h00; rd1 = 8'h00;
        @(negedge clk);
        bdir = 1'b0; bc1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) bc1 = 1'b0;
            if (d_oe0) begin oe0_cycles++; rd0 = d_out0; end
            if (d_oe1) begin oe1_cycles++; rd1 = d_out1; end
        end
    endtask

    task automatic peek(input logic [3:0] a);
        core_addr = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bdir = 1'b0; bc1 = 1'b0; chip_sel = 1'b0; d_in = 8'h00; core_addr = 4'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (d_out0 !== 8'h00) begin n_fail++; $display("FAIL reset_d_out got=%h exp=00", d_out0); end
        n_cmp++; if (d_oe0 !== 1'b0) begin n_fail++; $display("FAIL reset_d_oe got=%b exp=0", d_oe0); end
        n_cmp++; if (wr_strobe0 !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe0); end
        n_cmp++; if (wr_addr0 !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr0); end
        n_cmp++; if (env0 !== 1'b0) begin n_fail++; $display("FAIL reset_env got=%b exp=0", env0); end
        peek(4'd7);
        n_cmp++; if (core_data0 !== 8'h00) begin n_fail++; $display("FAIL reset_core_data got=%h exp=00", core_data0); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_basic();
        int s0, s1, e0;
        s0 = stb0_cnt; s1 = stb1_cnt; e0 = env0_cnt;
        bus_op(1'b1, 1'b1, 8'h07);
        bus_op(1'b1, 1'b0, 8'hBE);
        n_cmp++; if (stb0_cnt - s0 !== 1) begin n_fail++; $display("FAIL wr_strobe_count got=%0d exp=1", stb0_cnt - s0); end
        n_cmp++; if (wr_addr0 !== 4'd7) begin n_fail++; $display("FAIL wr_addr got=%h exp=7", wr_addr0); end
        n_cmp++; if (env0_cnt - e0 !== 0) begin n_fail++; $display("FAIL env_not_r13 got=%0d exp=0", env0_cnt - e0); end
        n_cmp++; if (stb1_cnt - s1 !== 0) begin n_fail++; $display("FAIL other_chip_strobe got=%0d exp=0", stb1_cnt - s1); end
        peek(4'd7);
        n_cmp++; if (core_data0 !== 8'hBE) begin n_fail++; $display("FAIL core_data_r7 got=%h exp=BE", core_data0); end
    endtask

    task automatic test_read_mask();
        int oe0, oe1;
        logic [7:0] rd0, rd1;
        bus_op(1'b1, 1'b1, 8'h01);
        bus_op(1'b1, 1'b0, 8'hFF);
        do_read(oe0, oe1, rd0, rd1);
        n_cmp++; if (oe0 !== 4) begin n_fail++; $display("FAIL read_oe_cycles got=%0d exp=4", oe0); end
        n_cmp++; if (rd0 !== 8'h0F) begin n_fail++; $display("FAIL read_r1_mask got=%h exp=0F", rd0); end
        n_cmp++; if (d_oe0 !== 1'b0) begin n_fail++; $display("FAIL read_oe_released got=%b exp=0", d_oe0); end
        bus_op(1'b1, 1'b1, 8'h08);
        bus_op(1'b1, 1'b0, 8'hFF);
        do_read(oe0, oe1, rd0, rd1);
        n_cmp++; if (rd0 !== 8'h1F) begin n_fail++; $display("FAIL read_r8_mask got=%h exp=1F", rd0); end
        peek(4'd1);
        n_cmp++; if (core_data0 !== 8'h0F) begin n_fail++; $display("FAIL core_data_r1 got=%h exp=0F", core_data0); end
    endtask

    task automatic test_env_restart();
        int s0, e0, b0;
        s0 = stb0_cnt; e0 = env0_cnt; b0 = both0_cnt;
        bus_op(1'b1, 1'b1, 8'h0D);
        bus_op(1'b1, 1'b0, 8'h0A);
        n_cmp++; if (stb0_cnt - s0 !== 1) begin n_fail++; $display("FAIL r13_strobe got=%0d exp=1", stb0_cnt - s0); end
        n_cmp++; if (env0_cnt - e0 !== 1) begin n_fail++; $display("FAIL r13_env got=%0d exp=1", env0_cnt - e0); end
        n_cmp++; if (both0_cnt - b0 !== 1) begin n_fail++; $display("FAIL r13_env_coincident got=%0d exp=1", both0_cnt - b0); end
        peek(4'd13);
        n_cmp++; if (core_data0 !== 8'h0A) begin n_fail++; $display("FAIL core_data_r13 got=%h exp=0A", core_data0); end
    endtask

    task automatic test_addr_hi();
        int s0, e0;
        s0 = stb0_cnt; e0 = env0_cnt;
        bus_op(1'b1, 1'b1, 8'h37);
        n_cmp++; if (stb0_cnt - s0 !== 0) begin n_fail++; $display("FAIL latch_no_strobe got=%0d exp=0", stb0_cnt - s0); end
        bus_op(1'b1, 1'b0, 8'h05);
        n_cmp++; if (wr_addr0 !== 4'd13) begin n_fail++; $display("FAIL addr_hi_wr_addr got=%h exp=D", wr_addr0); end
        n_cmp++; if (env0_cnt - e0 !== 1) begin n_fail++; $display("FAIL addr_hi_env got=%0d exp=1", env0_cnt - e0); end
        peek(4'd13);
        n_cmp++; if (core_data0 !== 8'h05) begin n_fail++; $display("FAIL addr_hi_r13 got=%h exp=05", core_data0); end
        peek(4'd7);
        n_cmp++; if (core_data0 !== 8'hBE) begin n_fail++; $display("FAIL addr_hi_r7_intact got=%h exp=BE", core_data0); end
    endtask

    task automatic test_chip_sel();
        int s0, s1, oe0, oe1;
        logic [7:0] rd0, rd1;
        s0 = stb0_cnt; s1 = stb1_cnt;
        chip_sel = 1'b1;
        bus_op(1'b1, 1'b1, 8'h00);
        bus_op(1'b1, 1'b0, 8'h55);
        n_cmp++; if (stb1_cnt - s1 !== 1) begin n_fail++; $display("FAIL cs_chip1_strobe got=%0d exp=1", stb1_cnt - s1); end
        n_cmp++; if (stb0_cnt - s0 !== 0) begin n_fail++; $display("FAIL cs_chip0_strobe got=%0d exp=0", stb0_cnt - s0); end
        peek(4'd0);
        n_cmp++; if (core_data1 !== 8'h55) begin n_fail++; $display("FAIL cs_chip1_r0 got=%h exp=55", core_data1); end
        n_cmp++; if (core_data0 !== 8'h00) begin n_fail++; $display("FAIL cs_chip0_r0 got=%h exp=00", core_data0); end
        do_read(oe0, oe1, rd0, rd1);
        n_cmp++; if (oe0 !== 0) begin n_fail++; $display("FAIL cs_chip0_oe got=%0d exp=0", oe0); end
        n_cmp++; if (oe1 !== 4) begin n_fail++; $display("FAIL cs_chip1_oe got=%0d exp=4", oe1); end
        n_cmp++; if (rd1 !== 8'h55) begin n_fail++; $display("FAIL cs_chip1_read got=%h exp=55", rd1); end
        chip_sel = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int s0;
        bus_op(1'b1, 1'b1, 8'h02);
        s0 = stb0_cnt;
        @(negedge clk);
        bdir = 1'b1; bc1 = 1'b0; d_in = 8'h11;
        repeat (4) @(negedge clk);
        reset = 1'b1; d_in = 8'h22;
        @(negedge clk);
        n_cmp++; if (d_oe0 !== 1'b0 || d_out0 !== 8'h00 || wr_strobe0 !== 1'b0 || env0 !== 1'b0 || wr_addr0 !== 4'h0)
            begin n_fail++; $display("FAIL midreset_outputs got=%b/%h/%b/%b/%h exp=0/00/0/0/0", d_oe0, d_out0, wr_strobe0, env0, wr_addr0); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        bdir = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (stb0_cnt - s0 !== 1) begin n_fail++; $display("FAIL midreset_commits got=%0d exp=1", stb0_cnt - s0); end
        n_cmp++; if (wr_addr0 !== 4'h0) begin n_fail++; $display("FAIL midreset_wr_addr got=%h exp=0", wr_addr0); end
        peek(4'd0);
        n_cmp++; if (core_data0 !== 8'h22) begin n_fail++; $display("FAIL midreset_r0 got=%h exp=22", core_data0); end
        peek(4'd2);
        n_cmp++; if (core_data0 !== 8'h00) begin n_fail++; $display("FAIL midreset_r2 got=%h exp=00", core_data0); end
        peek(4'd7);
        n_cmp++; if (core_data0 !== 8'h00) begin n_fail++; $display("FAIL midreset_r7_cleared got=%h exp=00", core_data0); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_mask();
        test_env_restart();
        test_addr_hi();
        test_chip_sel();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
